// File: rtl/vpu_pkg.sv
// Shared VPU sprite definitions: hit-entry and attribute layouts, scan limits, collector states.
package vpu_pkg;

  localparam int HIT_W        = 23;
  localparam int HIT_SLOT_LSB = 18;
  localparam int HIT_ID_LSB   = 9;
  localparam int HIT_OX_LSB   = 5;
  localparam int HIT_OY_LSB   = 1;
  localparam int HIT_VLD_BIT  = 0;

  localparam int ATTR_W      = 29;
  localparam int ATTR_ID_LSB = 20;
  localparam int ATTR_X_LSB  = 10;
  localparam int ATTR_Y_LSB  = 0;

  localparam int SLOT_W = 5;
  localparam int ID_W   = 9;
  localparam int OFF_W  = 4;

  localparam int MAX_HITS    = 4;
  localparam int SPRITE_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [HIT_W-1:0] pack_hit(input logic [SLOT_W-1:0] slot,
                                                input logic [ID_W-1:0]   id,
                                                input logic [OFF_W-1:0]  ox,
                                                input logic [OFF_W-1:0]  oy);
    logic [HIT_W-1:0] e;
    e = '0;
    e[HIT_SLOT_LSB +: SLOT_W] = slot;
    e[HIT_ID_LSB +: ID_W]     = id;
    e[HIT_OX_LSB +: OFF_W]    = ox;
    e[HIT_OY_LSB +: OFF_W]    = oy;
    e[HIT_VLD_BIT]            = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational test of one sprite attribute against a pixel; differences are taken
// one bit wider than the coordinates so a pixel left of / above the sprite never wraps into a hit.
module sprite_hit_test
  import vpu_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [ATTR_W-1:0]  attr,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               hit,
  output logic [OFF_W-1:0]   off_x,
  output logic [OFF_W-1:0]   off_y
);

  logic [ID_W-1:0]  id;
  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;

  assign id = attr[ATTR_ID_LSB +: ID_W];
  assign dx = {1'b0, px} - {1'b0, attr[ATTR_X_LSB +: COORD_W]};
  assign dy = {1'b0, py} - {1'b0, attr[ATTR_Y_LSB +: COORD_W]};

  assign hit   = (id != '0) &&
                 (dx < (COORD_W+1)'(SPRITE_SIZE)) &&
                 (dy < (COORD_W+1)'(SPRITE_SIZE));
  assign off_x = dx[OFF_W-1:0];
  assign off_y = dy[OFF_W-1:0];

endmodule

// File: rtl/sprite_hit_collector.sv
// Sequentially scans the sprite table (one slot/cycle) for up to 4 hits, pulses start, then
// holds entries until fetch_done; new requests are refused (ready low) outside IDLE.
module sprite_hit_collector
  import vpu_pkg::*;
#(
  parameter int NUM_SPRITES = 32,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               ready,
  input  logic               wr_en,
  input  logic [4:0]         wr_addr,
  input  logic [28:0]        wr_data,
  output logic               start,
  output logic [22:0]        h0_in,
  output logic [22:0]        h1_in,
  output logic [22:0]        h2_in,
  output logic [22:0]        h3_in,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  input  logic               fetch_done
);

  logic [ATTR_W-1:0] attr_tbl [NUM_SPRITES];
  state_t            state;
  logic [4:0]        idx;
  logic [2:0]        cnt;

  logic [ATTR_W-1:0] cur_attr;
  logic              hit;
  logic [OFF_W-1:0]  off_x;
  logic [OFF_W-1:0]  off_y;
  logic [HIT_W-1:0]  entry;

  // Combinational read: a same-cycle write lands at the edge, so the scan sees the old value.
  assign cur_attr = attr_tbl[idx];

  sprite_hit_test #(.COORD_W(COORD_W)) u_hit_test (
    .attr  (cur_attr),
    .px    (pix_x),
    .py    (pix_y),
    .hit   (hit),
    .off_x (off_x),
    .off_y (off_y)
  );

  assign entry = pack_hit(idx, cur_attr[ATTR_ID_LSB +: ID_W], off_x, off_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) attr_tbl[i] <= '0;
      state <= ST_IDLE;
      ready <= 1'b1;
      start <= 1'b0;
      h0_in <= '0;
      h1_in <= '0;
      h2_in <= '0;
      h3_in <= '0;
      pix_x <= '0;
      pix_y <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      if (wr_en) attr_tbl[wr_addr] <= wr_data;
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            pix_x <= px;
            pix_y <= py;
            h0_in <= '0;
            h1_in <= '0;
            h2_in <= '0;
            h3_in <= '0;
            cnt   <= '0;
            idx   <= '0;
            ready <= 1'b0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // First hit fills h3; the fetcher walks h3 down to h0.
          if (hit) begin
            case (cnt[1:0])
              2'd0:    h3_in <= entry;
              2'd1:    h2_in <= entry;
              2'd2:    h1_in <= entry;
              default: h0_in <= entry;
            endcase
            cnt <= cnt + 3'd1;
          end
          if ((hit && cnt == 3'(MAX_HITS - 1)) || idx == 5'(NUM_SPRITES - 1))
            state <= ST_EMIT;
          idx <= idx + 5'd1;
        end
        ST_EMIT: begin
          start <= 1'b1;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (fetch_done) begin
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_hit_collector.md
Name: sprite_hit_collector

Overview:
- Upstream neighbour of the VPU sprite pixel fetcher.
- For each requested screen pixel (px, py), scans an on-chip sprite attribute table and collects up to 4 covering sprites in priority order.
- Packs the hits into the 23-bit hit-entry format, pulses start to the fetcher, and holds the entries until the fetcher reports done.
- Also holds the attribute table, which the CPU side writes.

Parameters:
- NUM_SPRITES, 32, number of attribute-table slots; must be ≤ 32 because the slot index field is 5 bits.
- COORD_W, 10, screen coordinate width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  pixel lookup request
- px  in  COORD_W  pixel x, sampled when the request is accepted
- py  in  COORD_W  pixel y, sampled when the request is accepted
- ready  out  1  high only in IDLE; a request is accepted when req && ready
- wr_en  in  1  attribute table write strobe
- wr_addr  in  5  slot to write
- wr_data  in  29  {sprite_id[28:20], x[19:10], y[9:0]}; sprite_id 0 means the slot is empty
- start  out  1  one-cycle pulse to the fetcher; h0..h3 are valid in that cycle
- h0_in..h3_in  out  23 each  hit entries, held stable from start until fetch_done
- pix_x, pix_y  out  COORD_W each  latched coordinates of the pixel being resolved, for the downstream writer
- fetch_done  in  1  done pulse from the fetcher

Behaviour:
- Reset: all table slots cleared to sprite_id 0. State IDLE, ready=1, start=0, h0..h3=0, pix_x=pix_y=0. Reset mid-operation aborts the current lookup the same way; any pending fetch_done is ignored.
- Hit entry format: [22:18] slot index, [17:9] sprite_id, [8:5] off_x, [4:1] off_y, [0]=1. An unused entry is all zeros.
- Hit test, slot s: sprite_id≠0, px≥x, px−x≤15, py≥y, py−y≤15.
  - Compute the differences unsigned in COORD_W+1 bits so there is no wrap-around.
  - off_x = (px−x)[3:0], off_y = (py−y)[3:0].
- Priority order:
  - Lower slot index has higher priority.
  - The 1st hit goes to h3_in, then h2_in, h1_in, h0_in. The fetcher checks h3 first and stops at the first zero entry.
- State machine:
  - IDLE
    - On req&&ready: latch px/py into pix_x/pix_y, clear h0..h3 and the hit count, set scan index to 0, go to SCAN.
  - SCAN
    - Evaluate one slot per cycle; on a hit, write it into the next free entry.
    - Go to EMIT after slot NUM_SPRITES−1, or in the cycle the 4th hit is recorded (early exit).
  - EMIT
    - start=1 for exactly one cycle, then go to WAIT_DONE.
  - WAIT_DONE
    - Hold h0..h3; on fetch_done go to IDLE.
    - fetch_done seen outside WAIT_DONE is ignored.
- Latency from acceptance to start:
  - With k ≤ 3 hits: NUM_SPRITES+1 cycles.
  - With early exit, when the 4th hit is at slot j: j+2 cycles.
- Zero hits: start is still pulsed with all entries 0, so the fetcher returns pixel 0 (transparent).
- Table writes:
  - Accepted in every state; the slot is updated at the clock edge.
  - During SCAN, a slot already evaluated does not affect the current result. A slot evaluated later uses the new value.
  - A write and a read of the same slot in the same cycle use the old value.
- ready goes low the cycle after acceptance. req while not ready is ignored; it is not queued.

Decomposition:
- Shared package vpu_pkg holds:
  - HIT_W=23 and the hit-entry field offsets.
  - ATTR_W=29 and the attribute field offsets.
  - MAX_HITS=4.
  - SPRITE_SIZE=16.
  - State encoding.
- One natural sub-module: sprite_hit_test, a combinational comparator taking one attribute plus px/py and returning hit, off_x and off_y. It is reusable for a future parallel-scan variant.

Test Plan:
- Reset, empty table, req px=5 py=5 → start exactly 33 cycles after acceptance, h0..h3=0, ready low until fetch_done, then high the next cycle.
- Slot 2 = {id 7, x 100, y 50}, req px=103 py=60 → h3_in = {5'd2, 9'd7, 4'd3, 4'd10, 1'b1}, h0..h2 = 0, pix_x=103, pix_y=60.
- Slots 0, 3, 4, 9, 20 all cover (200,200) → h3=slot 0, h2=slot 3, h1=slot 4, h0=slot 9; start 11 cycles after acceptance; slot 20 is never reported.
- Boundary, sprite x=100 y=50, py=50: px=99 miss; px=100 hit with off_x 0; px=115 hit with off_x 15; px=116 miss. Repeat with x=630 and px=639 to confirm no wrap-around.
- Write during SCAN: overwrite slot 25 to cover the pixel while the scan index is 10 → reported; overwrite slot 5 at scan index 10 → the old value is used.
- Assert rst during SCAN and during WAIT_DONE → next cycle ready=1, start=0, h=0, table empty; a stale fetch_done afterwards has no effect.
